// File: rtl/instr_reader_alu_if.sv
// ============================================================================
// Module      : instr_reader_alu_if
// Description : Result port of the instruction reader: valid/ready handshake
//               carrying the signed result, source address, opcode and error.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface instr_reader_alu_if #(
    parameter int RES_W = 64
);
    logic                    res_valid;
    logic                    res_ready;
    logic signed [RES_W-1:0] res_data;
    logic [4:0]              res_addr;
    logic [2:0]              res_opc;
    logic                    res_err;

    modport master (
        output res_valid,
        output res_data,
        output res_addr,
        output res_opc,
        output res_err,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_addr,
        input  res_opc,
        input  res_err,
        output res_ready
    );
endinterface

`default_nettype wire

// File: rtl/instr_reader_alu.sv
// ============================================================================
// Module      : instr_reader_alu
// Description : Walks a window of instruction-register locations, executes each
//               {opc, op_a, op_b} word and streams results over valid/ready.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_reader_alu #(
    parameter int RES_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            first_addr,
    input  logic [5:0]            count,
    output logic [4:0]            read_pointer,
    input  logic [66:0]           instruction_word,
    instr_reader_alu_if.master    res,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;
    localparam logic [5:0] MAX_COUNT = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  remaining;
    logic [2:0]  cap_opc;
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    logic [4:0]  cap_addr;

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] alu_res;
    logic                    alu_err;

    // Operands are widened before dividing so that MIN_INT / -1 cannot overflow.
    always_comb begin
        a_ext   = {{(RES_W-32){cap_a[31]}}, cap_a};
        b_ext   = {{(RES_W-32){cap_b[31]}}, cap_b};
        alu_res = '0;
        alu_err = 1'b0;
        case (cap_opc)
            OPC_ZERO:  alu_res = '0;
            OPC_PASSA: alu_res = a_ext;
            OPC_PASSB: alu_res = b_ext;
            OPC_ADD:   alu_res = a_ext + b_ext;
            OPC_SUB:   alu_res = a_ext - b_ext;
            OPC_MULT:  alu_res = a_ext * b_ext;
            OPC_DIV: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext / b_ext;
            end
            OPC_MOD: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext % b_ext;
            end
            default:   alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            remaining     <= '0;
            read_pointer  <= '0;
            cap_opc       <= OPC_ZERO;
            cap_a         <= '0;
            cap_b         <= '0;
            cap_addr      <= '0;
            res.res_valid <= 1'b0;
            res.res_data  <= '0;
            res.res_addr  <= '0;
            res.res_opc   <= OPC_ZERO;
            res.res_err   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        read_pointer <= first_addr;
                        remaining    <= (count > MAX_COUNT) ? MAX_COUNT : count;
                        busy         <= 1'b1;
                        if (count == 6'd0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    cap_opc  <= instruction_word[66:64];
                    cap_a    <= instruction_word[63:32];
                    cap_b    <= instruction_word[31:0];
                    cap_addr <= read_pointer;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    res.res_data  <= alu_res;
                    res.res_err   <= alu_err;
                    res.res_addr  <= cap_addr;
                    res.res_opc   <= cap_opc;
                    res.res_valid <= 1'b1;
                    state         <= S_OUT;
                end
                S_OUT: begin
                    if (res.res_ready) begin
                        res.res_valid <= 1'b0;
                        read_pointer  <= read_pointer + 5'd1;
                        remaining     <= remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_reader_alu.sv
// ============================================================================
// Module      : tb_instr_reader_alu
// Description : Self-checking bench: directed walks plus randomized walks
//               scored against a queue-based behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_reader_alu;

    localparam logic [2:0] ZERO = 3'd0, PASSA = 3'd1, PASSB = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB  = 3'd4, MULT  = 3'd5, DIV   = 3'd6, MOD = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [5:0]  count = '0;
    logic [4:0]  read_pointer;
    logic [66:0] instruction_word;
    logic        busy;
    logic        done;
    logic [66:0] mem [32];

    instr_reader_alu_if #(.RES_W(64)) rif ();

    instr_reader_alu #(.RES_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res              (rif),
        .busy             (busy),
        .done             (done)
    );

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    typedef struct {
        longint     data;
        logic [4:0] addr;
        logic [2:0] opc;
        bit         err;
    } exp_t;

    exp_t       expq[$];
    longint     data_log[$];
    logic [4:0] addr_log[$];
    bit         err_log[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [66:0] mk(input logic [2:0] o, input int a, input int b);
        return {o, a, b};
    endfunction

    function automatic longint model_alu(input logic [2:0] opc, input int a, input int b,
                                         output bit err);
        longint la = a;
        longint lb = b;
        longint r  = 0;
        err = 1'b0;
        case (opc)
            ZERO:  r = 0;
            PASSA: r = la;
            PASSB: r = lb;
            ADD:   r = la + lb;
            SUB:   r = la - lb;
            MULT:  r = la * lb;
            DIV:   if (lb == 0) err = 1'b1; else r = la / lb;
            default: if (lb == 0) err = 1'b1; else r = la % lb;
        endcase
        return r;
    endfunction

    // Expected stream for one walk: clamp, then consecutive addresses modulo 32.
    task automatic push_walk(input logic [4:0] fa, input logic [5:0] cn);
        int n = (cn > 32) ? 32 : int'(cn);
        for (int i = 0; i < n; i++) begin
            exp_t        e;
            logic [4:0]  ad = fa + 5'(i);
            logic [66:0] w  = mem[ad];
            e.addr = ad;
            e.opc  = w[66:64];
            e.data = model_alu(w[66:64], int'(w[63:32]), int'(w[31:0]), e.err);
            expq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rif.res_valid) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result addr=%0d data=%0d required=no_result",
                         rif.res_addr, rif.res_data);
            end else begin
                chk("res_data", rif.res_data, expq[0].data);
                chk("res_addr", longint'(rif.res_addr), longint'(expq[0].addr));
                chk("res_opc", longint'(rif.res_opc), longint'(expq[0].opc));
                chk("res_err", longint'(rif.res_err), longint'(expq[0].err));
                chk("read_pointer_at_result", longint'(read_pointer), longint'(expq[0].addr));
                if (rif.res_ready) begin
                    data_log.push_back(rif.res_data);
                    addr_log.push_back(rif.res_addr);
                    err_log.push_back(rif.res_err);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic do_start(input logic [4:0] fa, input logic [5:0] cn, input bit accept);
        @(posedge clk); #1;
        start = 1'b1; first_addr = fa; count = cn;
        if (accept) push_walk(fa, cn);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit rnd, output int lat);
        lat = 1;
        while (!done && lat < bound) begin
            @(posedge clk); #1;
            lat++;
            if (rnd) rif.res_ready = 1'($urandom_range(0, 1));
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", bound);
        end
    endtask

    task automatic wait_valid(input int bound, output int lat);
        lat = 1;
        while (!rif.res_valid && lat < bound) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic clear_logs();
        data_log.delete(); addr_log.delete(); err_log.delete();
    endtask

    initial begin
        int lat;
        longint held;

        rif.res_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_read_pointer", longint'(read_pointer), 0);
        chk("reset_res_valid", longint'(rif.res_valid), 0);
        chk("reset_res_opc", longint'(rif.res_opc), longint'(ZERO));
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        reset = 1'b0;

        // Basic walk and latency.
        mem[0] = mk(ADD, 5, 3); mem[1] = mk(SUB, 2, 9); mem[2] = mk(MULT, -4, 6);
        rif.res_ready = 1'b1;
        clear_logs();
        do_start(5'd0, 6'd3, 1'b1);
        chk("busy_after_start", longint'(busy), 1);
        wait_valid(20, lat);
        chk("first_valid_latency", lat, 3);
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("done_latency", lat, 10);
        @(posedge clk); #1;
        chk("done_one_cycle", longint'(done), 0);
        chk("busy_cleared", longint'(busy), 0);
        chk("t1_count", data_log.size(), 3);
        if (data_log.size() == 3) begin
            chk("t1_r0", data_log[0], 8);
            chk("t1_r1", data_log[1], -7);
            chk("t1_r2", data_log[2], -24);
            chk("t1_a2", longint'(addr_log[2]), 2);
        end

        // Divide and modulo, including by zero.
        mem[3] = mk(DIV, -7, 2); mem[4] = mk(MOD, -7, 2); mem[5] = mk(DIV, 10, 0);
        clear_logs();
        do_start(5'd3, 6'd3, 1'b1);
        wait_done(60, 1'b0, lat);
        chk("t2_count", data_log.size(), 3);
        if (data_log.size() == 3) begin
            chk("div_neg", data_log[0], -3);
            chk("mod_neg", data_log[1], -1);
            chk("div_zero_data", data_log[2], 0);
            chk("div_zero_err", longint'(err_log[2]), 1);
            chk("div_ok_err", longint'(err_log[0]), 0);
        end

        // Address window wrap.
        mem[30] = mk(PASSA, 30, 0); mem[31] = mk(PASSB, 0, 31);
        mem[0]  = mk(ADD, -1, 1);   mem[1]  = mk(SUB, 0, 1);
        clear_logs();
        do_start(5'd30, 6'd4, 1'b1);
        wait_done(60, 1'b0, lat);
        chk("t3_count", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("wrap_a0", longint'(addr_log[0]), 30);
            chk("wrap_a1", longint'(addr_log[1]), 31);
            chk("wrap_a2", longint'(addr_log[2]), 0);
            chk("wrap_a3", longint'(addr_log[3]), 1);
        end

        // Backpressure hold with an ignored second start.
        mem[0] = mk(ADD, 5, 3); mem[1] = mk(SUB, 2, 9); mem[2] = mk(MULT, -4, 6);
        clear_logs();
        rif.res_ready = 1'b0;
        do_start(5'd0, 6'd3, 1'b1);
        wait_valid(20, lat);
        held = rif.res_data;
        do_start(5'd7, 6'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_valid", longint'(rif.res_valid), 1);
        chk("hold_data", rif.res_data, held);
        rif.res_ready = 1'b1;
        wait_done(60, 1'b0, lat);
        repeat (20) @(posedge clk);
        #1;
        chk("hold_total_results", data_log.size(), 3);

        // Zero-length walk.
        do_start(5'd4, 6'd0, 1'b1);
        chk("zero_busy", longint'(busy), 1);
        chk("zero_done", longint'(done), 1);
        @(posedge clk); #1;
        chk("zero_busy_after", longint'(busy), 0);
        chk("zero_done_after", longint'(done), 0);

        // Asynchronous reset while a result is pending.
        rif.res_ready = 1'b0;
        do_start(5'd0, 6'd3, 1'b1);
        wait_valid(20, lat);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("areset_valid", longint'(rif.res_valid), 0);
        chk("areset_data", rif.res_data, 0);
        chk("areset_addr", longint'(rif.res_addr), 0);
        chk("areset_rp", longint'(read_pointer), 0);
        chk("areset_busy", longint'(busy), 0);
        chk("areset_err", longint'(rif.res_err), 0);
        expq.delete();
        @(posedge clk); #2;
        reset = 1'b0;
        rif.res_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post_reset_busy", longint'(busy), 0);

        // Randomized walks against the model.
        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < 32; i++) begin
                int b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom);
                if ($urandom_range(0, 1) == 1) b = int'($urandom_range(0, 20)) - 10;
                mem[i] = mk(3'($urandom_range(0, 7)), int'($urandom), b);
            end
            do_start(5'($urandom_range(0, 31)), 6'($urandom_range(0, 40)), 1'b1);
            wait_done(800, 1'b1, lat);
            rif.res_ready = 1'b1;
            @(posedge clk); #1;
            chk("rand_drained", expq.size(), 0);
            expq.delete();
        end

        chk("final_busy", longint'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/instr_reader_alu.md
# instr_reader_alu

Reader and executor for the instruction register. On a start command it walks a window of register locations via `read_pointer`, samples each `instruction_word`, evaluates the operation, and presents one result per location on a valid/ready output port. It is the consuming end of the register's read port, used both as the downstream datapath and as the reference checker side in the lab testbench.

## Interface

Parameters:
- `RES_W`, default 64: result width, signed; must be ≥ 2×operand width.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to begin a walk; ignored while `busy`=1.
- `first_addr` input `address_t` (5): first location to read; sampled with `start`.
- `count` input 6: number of locations, 0..32; sampled with `start`.
- `read_pointer` output `address_t` (5): address to the instruction register read port.
- `instruction_word` input `instruction_t`: `{opc, op_a, op_b}`, combinational from `read_pointer`.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts the result.
- `res_data` output `RES_W`: signed result.
- `res_addr` output 5: location the result came from.
- `res_opc` output `opcode_t`: opcode executed.
- `res_err` output 1: divide or modulo by zero.
- `busy` output 1: walk in progress.
- `done` output 1: one-cycle pulse after the walk completes.

## Operation

- FSM states: IDLE, FETCH, EXEC, OUT, FIN.
- IDLE with `start`=1:
  - latch `first_addr` into `read_pointer` and `count` into a remaining counter.
  - if `count`=0, go to FIN; otherwise go to FETCH. `busy` goes to 1 on the same edge.
- FETCH: `read_pointer` is stable. At the clock edge, capture `instruction_word` and `read_pointer`, then go to EXEC.
- EXEC: compute the result from the captured word and register it into `res_*`. Set `res_valid`=1 and go to OUT.
- OUT: hold all `res_*` outputs stable while `res_valid`=1 and `res_ready`=0. On a handshake (`res_valid` && `res_ready`):
  - clear `res_valid`.
  - increment `read_pointer` modulo 32 (31 wraps to 0).
  - decrement the remaining counter.
  - go to FETCH if the remaining count is still nonzero, else go to FIN.
- FIN: `done`=1 for exactly one cycle, `busy` returns to 0, go to IDLE.
- Opcode evaluation (operands are signed 32-bit, sign-extended to `RES_W`):
  - ZERO → 0
  - PASSA → a
  - PASSB → b
  - ADD → a+b
  - SUB → a−b
  - MULT → a*b, full 64-bit product
  - DIV → a/b, truncated toward zero
  - MOD → a%b, sign follows the dividend
- For DIV or MOD with b=0: `res_data`=0 and `res_err`=1. In every other case `res_err`=0.
- No overflow is possible at `RES_W`=64.
- `count` of 32 or less wraps the address window; a `count` above 32 is clamped to 32.

## Timing

- Reset (asynchronous, in any state): FSM returns to IDLE and outputs take these values:
  - `read_pointer`=0, `res_valid`=0, `res_data`=0, `res_addr`=0
  - `res_opc`=ZERO, `res_err`=0, `busy`=0, `done`=0
- Reset mid-walk discards the walk; no further results are produced.
- Latency with `res_ready` held at 1:
  - `start` is sampled at edge 0.
  - FETCH occupies cycle 1.
  - EXEC occupies cycle 2.
  - `res_valid`=1 during cycle 3; the handshake occurs at the end of cycle 3.
  - Each further location takes 3 cycles.
  - `done` is asserted in the cycle after the last handshake.
- Backpressure:
  - `res_valid`, once high, stays high until the handshake.
  - `res_*` must not change while `res_valid`=1.
- `read_pointer` changes only on the edge that leaves OUT (after a handshake) or on the edge that accepts `start`.
- `start` arriving together with `done`, or while `busy`=1, is ignored and not queued.
- `res_ready` is don't-care while `res_valid`=0.

## Test plan

- Reset, then preload locations 0..2 with ADD a=5 b=3, SUB a=2 b=9, MULT a=−4 b=6. Pulse `start` with `first_addr`=0, `count`=3 and `res_ready`=1.
  - Expected results: 8, −7, −24 with `res_addr` 0, 1, 2.
  - First `res_valid` appears 3 cycles after `start`.
  - `done` is asserted 10 cycles after `start`.
- DIV a=−7 b=2 and MOD a=−7 b=2 → −3 and −1. DIV a=10 b=0 → `res_data`=0, `res_err`=1.
- `first_addr`=30, `count`=4 → `read_pointer` sequence 30, 31, 0, 1. Results are tagged with the matching `res_addr`.
- Hold `res_ready`=0 for 5 cycles on the first result → `res_valid` and all `res_*` stay stable. A second `start` pulse during the hold is ignored and only 3 results are produced in total.
- `count`=0 → no `res_valid`; `done` pulses 1 cycle after `start` and `busy` is high for that 1 cycle only.
- Assert `reset` asynchronously (not aligned to a clock edge) while in OUT → all outputs take their reset values immediately. No result appears afterward until a new `start`.
